// File: rtl/rand_pkg.sv
// ---------------------------------------------------------------------------
// rand_pkg
// Shared definitions for the rand_roller slice: the roll FSM state encoding
// and the tap mask / width of the 16-bit Fibonacci LFSR.
// ---------------------------------------------------------------------------
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        DONE
    } state_t;

    localparam int unsigned LFSR_W = 16;

    // Feedback taps at bits 15, 13, 12 and 10; feedback is the XOR of the
    // tapped bits, shifted in at bit 0.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, stepped every clock.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, state <= SEED
//   i_load  : load i_seed this cycle (a zero seed loads SEED, so the
//             register can never lock up in the all-zero state)
//   i_seed  : seed value
//   o_state : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import rand_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_state
);

    logic feedback;

    assign feedback = ^(o_state & LFSR_TAPS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_state <= SEED;
        end else if (i_load) begin
            o_state <= (i_seed == '0) ? SEED : i_seed;
        end else begin
            o_state <= {o_state[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/rand_roller.sv
// ---------------------------------------------------------------------------
// rand_roller
// Dice-style roller: on a start pulse the displayed value is refreshed from
// the LFSR NUM_UPDATES times with a growing interval (BASE_INTERVAL, then
// +INTERVAL_STEP each update), so the display visibly slows down. The final
// value is pushed into a small history.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : single-cycle start pulse (accepted in IDLE only)
//   i_stop         : force the final update now (ROLL only)
//   i_seed_load    : load i_seed into the LFSR (IDLE only)
//   i_seed         : seed value
//   i_hist_sel     : history index, 0 = newest
//   o_random_out   : displayed value
//   o_memory_out   : history[i_hist_sel], 0 when out of range
//   o_hist_count   : number of valid history entries (saturating)
//   o_busy         : roll in progress (ROLL or DONE)
//   o_done         : one-cycle roll-complete pulse
// ---------------------------------------------------------------------------
module rand_roller
    import rand_pkg::*;
#(
    parameter int unsigned       WIDTH         = 4,
    parameter int unsigned       HIST_DEPTH    = 4,
    parameter int unsigned       BASE_INTERVAL = 2_500_000,
    parameter int unsigned       INTERVAL_STEP = 2_500_000,
    parameter int unsigned       NUM_UPDATES   = 10,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_stop,
    input  logic                            i_seed_load,
    input  logic [LFSR_W-1:0]               i_seed,
    input  logic [$clog2(HIST_DEPTH)-1:0]   i_hist_sel,
    output logic [WIDTH-1:0]                o_random_out,
    output logic [WIDTH-1:0]                o_memory_out,
    output logic [$clog2(HIST_DEPTH+1)-1:0] o_hist_count,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);
    localparam logic [63:0] INTERVAL_MAX =
        64'(BASE_INTERVAL) + 64'(NUM_UPDATES) * 64'(INTERVAL_STEP);

    generate
        if (INTERVAL_MAX >= 64'h1_0000_0000) begin : g_interval_overflow
            $error("rand_roller: BASE_INTERVAL + NUM_UPDATES*INTERVAL_STEP overflows 32 bits");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [31:0]       counter;
    logic [31:0]       interval;
    logic [7:0]        upd_count;
    logic [WIDTH-1:0]  hist [HIST_DEPTH];
    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_unused;

    logic in_idle, in_roll;
    logic start_acc, seed_load, tick, roll_final, roll_update;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (seed_load),
        .i_seed  (i_seed),
        .o_state (lfsr_state)
    );

    // Only the low WIDTH bits are displayed; the rest only feed the LFSR.
    assign lfsr_unused = ^lfsr_state;

    assign in_idle     = (state == IDLE);
    assign in_roll     = (state == ROLL);
    assign start_acc   = in_idle && i_start;
    assign seed_load   = in_idle && i_seed_load;
    assign tick        = in_roll && (counter == interval - 32'd1);
    // A stop that lands on the scheduled last tick is the same single final
    // update, so the history is pushed once.
    assign roll_final  = in_roll && (i_stop || (tick && (upd_count == 8'(NUM_UPDATES - 1))));
    assign roll_update = tick || roll_final;

    assign o_busy = (state == ROLL) || (state == DONE);
    assign o_done = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start)    state_next = ROLL;
            ROLL:    if (roll_final) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            counter      <= '0;
            interval     <= BASE_INTERVAL;
            upd_count    <= '0;
            o_random_out <= '0;
            o_hist_count <= '0;
            for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else if (start_acc) begin
            counter   <= '0;
            interval  <= BASE_INTERVAL;
            upd_count <= '0;
        end else if (in_roll) begin
            if (roll_update) begin
                counter      <= '0;
                interval     <= interval + INTERVAL_STEP;
                upd_count    <= upd_count + 8'd1;
                o_random_out <= lfsr_state[WIDTH-1:0];
            end else begin
                counter <= counter + 32'd1;
            end
            if (roll_final) begin
                for (int unsigned k = HIST_DEPTH - 1; k > 0; k--) begin
                    hist[k] <= hist[k-1];
                end
                hist[0] <= lfsr_state[WIDTH-1:0];
                if (o_hist_count != CNT_W'(HIST_DEPTH)) begin
                    o_hist_count <= o_hist_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_memory_out = '0;
        if (32'(i_hist_sel) < HIST_DEPTH) begin
            o_memory_out = hist[i_hist_sel];
        end
    end

endmodule

// File: tb/tb_rand_roller.sv
// ---------------------------------------------------------------------------
// tb_rand_roller
// Directed, table-driven bench for rand_roller with BASE_INTERVAL=2,
// INTERVAL_STEP=1, NUM_UPDATES=3, HIST_DEPTH=4, WIDTH=4. Each table row is
// one clock edge: the inputs applied, whether the LFSR load is expected to
// take effect, whether a display update is expected, and the expected
// busy/done/hist_count after the edge. A reference LFSR supplies the
// expected displayed values.
// ---------------------------------------------------------------------------
module tb_rand_roller;

    logic        clk = 1'b0;
    logic        rst, start, stop, sload;
    logic [15:0] seed;
    logic [1:0]  hsel;
    logic [3:0]  rout, mout;
    logic [2:0]  hcnt;
    logic        busy, done;

    always #5 clk = ~clk;

    rand_roller #(
        .WIDTH         (4),
        .HIST_DEPTH    (4),
        .BASE_INTERVAL (2),
        .INTERVAL_STEP (1),
        .NUM_UPDATES   (3),
        .SEED          (16'hACE1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_seed_load  (sload),
        .i_seed       (seed),
        .i_hist_sel   (hsel),
        .o_random_out (rout),
        .o_memory_out (mout),
        .o_hist_count (hcnt),
        .o_busy       (busy),
        .o_done       (done)
    );

    typedef struct {
        bit          rst, start, stop, sload;
        logic [15:0] seed;
        bit          ld, upd, busy, done;
        int          cnt;
    } vec_t;

    vec_t        vecs[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m, m_pre;
    logic [3:0]  exp_rand;
    logic [3:0]  finals[5];

    function automatic logic [15:0] ref_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, advancing the reference LFSR alongside the DUT.
    task automatic edge_step(input bit r, input bit ld);
        m_pre = m;
        @(posedge clk);
        if (r)       m = 16'hACE1;
        else if (ld) m = (seed == 16'h0) ? 16'hACE1 : seed;
        else         m = ref_next(m);
        #1;
    endtask

    task automatic add(input bit r, input bit st, input bit sp, input bit sl,
                       input logic [15:0] sd, input bit ld, input bit upd,
                       input bit bz, input bit dn, input int cnt);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.sload = sl; v.seed = sd;
        v.ld = ld; v.upd = upd; v.busy = bz; v.done = dn; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic idle_rows(input int n, input bit bz, input int cnt);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 16'h0, 0, 0, bz, 0, cnt);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; sload = 1'b0;
        seed = 16'h0; hsel = 2'd0;
        m = 16'hACE1; exp_rand = 4'h0;

        // ---- reset, then one idle cycle: fixed constants ----
        rst = 1'b1;
        edge_step(1, 0);
        rst = 1'b0;
        check("rst_lfsr",  dut.lfsr_state, 16'hACE1);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_cnt",   hcnt, 0);
        check("rst_rand",  rout, 0);
        edge_step(0, 0);
        check("idle_lfsr", dut.lfsr_state, 16'h59C3);
        check("idle_rand", rout, 0);
        check("idle_busy", busy, 0);
        check("idle_cnt",  hcnt, 0);

        // ---- table: rst st sp sl seed ld upd busy done cnt ----
        // Full roll: updates at E2, E5, E9; DONE E9..E10
        add(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0);   // E0
        idle_rows(1, 1, 0);                       // E1
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 0, 0);   // E2
        idle_rows(2, 1, 0);                       // E3, E4
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 0, 0);   // E5
        idle_rows(3, 1, 0);                       // E6..E8
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 1, 1);   // E9 final
        idle_rows(1, 0, 1);                       // E10
        add(0, 0, 1, 0, 16'h0, 0, 0, 0, 0, 1);   // stop in IDLE ignored
        // Early stop at E3
        add(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);   // reset
        add(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 0);   // E0
        idle_rows(1, 1, 0);                       // E1
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 0, 0);   // E2
        add(0, 0, 1, 0, 16'h0, 0, 1, 1, 1, 1);   // E3 stop
        idle_rows(1, 0, 1);                       // E4
        idle_rows(1, 0, 1);                       // E5: no update
        // Stop coinciding with the scheduled final update
        add(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 1);   // E0
        idle_rows(1, 1, 1);
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 0, 1);   // E2
        idle_rows(2, 1, 1);
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 0, 1);   // E5
        idle_rows(3, 1, 1);
        add(0, 0, 1, 0, 16'h0, 0, 1, 1, 1, 2);   // E9 final + stop
        idle_rows(2, 0, 2);
        // Start / seed load ignored while busy; seed loads in IDLE
        add(0, 1, 0, 0, 16'h0,    0, 0, 1, 0, 2); // E0
        add(0, 1, 0, 0, 16'h0,    0, 0, 1, 0, 2); // E1 start ignored
        add(0, 0, 0, 1, 16'h1234, 0, 1, 1, 0, 2); // E2 seed ignored
        add(0, 1, 0, 0, 16'h0,    0, 0, 1, 0, 2); // E3
        add(0, 0, 0, 1, 16'h1234, 0, 0, 1, 0, 2); // E4
        add(0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 2); // E5
        idle_rows(3, 1, 2);
        add(0, 0, 0, 0, 16'h0,    0, 1, 1, 1, 3); // E9 final
        add(0, 1, 0, 1, 16'h1234, 0, 0, 0, 0, 3); // E10 in DONE: ignored
        add(0, 0, 0, 1, 16'h0,    1, 0, 0, 0, 3); // zero seed -> SEED
        idle_rows(1, 0, 3);
        add(0, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 3); // nonzero seed
        idle_rows(1, 0, 3);
        // Reset mid-roll at E4
        add(0, 1, 0, 0, 16'h0, 0, 0, 1, 0, 3);   // E0
        idle_rows(1, 1, 3);
        add(0, 0, 0, 0, 16'h0, 0, 1, 1, 0, 3);   // E2
        idle_rows(1, 1, 3);
        add(1, 0, 1, 0, 16'h0, 0, 0, 0, 0, 0);   // E4 reset (stop too)
        idle_rows(6, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            sload = vecs[i].sload; seed = vecs[i].seed;
            edge_step(vecs[i].rst, vecs[i].ld);
            if (vecs[i].rst)      exp_rand = 4'h0;
            else if (vecs[i].upd) exp_rand = m_pre[3:0];
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            check($sformatf("v%0d_cnt",  i), hcnt, vecs[i].cnt);
            check($sformatf("v%0d_rand", i), rout, exp_rand);
            check($sformatf("v%0d_lfsr", i), dut.lfsr_state, m);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; sload = 1'b0; seed = 16'h0;

        // History cleared by the mid-roll reset
        for (int k = 0; k < 4; k++) begin
            hsel = 2'(k);
            #1;
            check($sformatf("clr_hist%0d", k), mout, 0);
        end

        // ---- five complete rolls: saturation and history order ----
        rst = 1'b1;
        edge_step(1, 0);
        rst = 1'b0;
        for (int r = 0; r < 5; r++) begin
            start = 1'b1;
            edge_step(0, 0);
            start = 1'b0;
            for (int e = 1; e <= 10; e++) begin
                edge_step(0, 0);
                if (e == 9) begin
                    finals[r] = m_pre[3:0];
                    check($sformatf("roll%0d_done", r), done, 1);
                end
            end
            check($sformatf("roll%0d_cnt", r), hcnt, (r < 4) ? r + 1 : 4);
            check($sformatf("roll%0d_busy", r), busy, 0);
        end
        check("hist_rand", rout, finals[4]);
        for (int k = 0; k < 4; k++) begin
            hsel = 2'(k);
            #1;
            check($sformatf("hist%0d", k), mout, finals[4-k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
